// File: rtl/alu_seq_pkg.sv
// Shared widths and FSM state type for the ALU opcode sequencer.
//   OP_W  : ALU opcode width
//   OPD_W : ALU operand width
//   RES_W : ALU result width
//   IDX_W : program slot index width (NSLOT = 2**IDX_W slots)
package alu_seq_pkg;

  localparam int OP_W  = 3;
  localparam int OPD_W = 3;
  localparam int RES_W = 6;
  localparam int IDX_W = 3;
  localparam int NSLOT = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that measures how long each opcode is held.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_ena      : global enable; low freezes the count
//   i_load     : load DWELL-1 (takes priority over i_dec)
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : count is zero
module dwell_timer #(
  parameter int DWELL = 12000000,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      if (i_load) begin
        r_cnt <= LOAD_VAL;
      end else if (i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps a small ALU through a programmed list of opcodes, holding each one
// for DWELL cycles and capturing each result for display.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   ena                 : enable; low freezes every register
//   a_in, b_in, load    : operands, latched on a rising edge of load (idle only)
//   prog_we/addr/op     : program slot write (idle only)
//   prog_len, loop      : last slot index of a run, restart-at-slot-0 flag
//   start, stop         : rising-edge run start, level abort
//   alu_a/b/ctrl        : operands and opcode presented to the ALU
//   alu_result          : combinational ALU result
//   result_out/valid    : last captured result and one-cycle capture pulse
//   busy, done, step_idx: run status
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DWELL = 12000000,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [OPD_W-1:0] a_in,
  input  logic [OPD_W-1:0] b_in,
  input  logic             load,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [OP_W-1:0]  prog_op,
  input  logic [IDX_W-1:0] prog_len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic [OPD_W-1:0] alu_a,
  output logic [OPD_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [RES_W-1:0] alu_result,
  output logic [RES_W-1:0] result_out,
  output logic             result_valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_idx
);

  state_t           r_state, w_next_state;
  logic             r_start_q, r_load_q;
  logic             w_start_edge, w_load_edge, w_go;
  logic             w_zero, w_last, w_cnt_load, w_cnt_dec;
  logic             w_busy, w_done;
  logic [OP_W-1:0]  r_prog [NSLOT];
  logic [OPD_W-1:0] r_alu_a, r_alu_b;
  logic [OP_W-1:0]  r_alu_ctrl;
  logic [IDX_W-1:0] r_step_idx, w_idx_inc;
  logic [RES_W-1:0] r_result_out;
  logic             r_result_valid;

  assign w_start_edge = start & ~r_start_q;
  assign w_load_edge  = load & ~r_load_q;
  assign w_go         = w_start_edge & ~stop;
  assign w_idx_inc    = r_step_idx + IDX_W'(1);
  // The last slot also ends the run so step_idx never wraps without loop,
  // even if prog_len was lowered below the current index mid-run.
  assign w_last       = (r_step_idx == prog_len) || (r_step_idx == '1);
  assign w_cnt_load   = (r_state == ISSUE);
  assign w_cnt_dec    = (r_state == HOLD);

  dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ena  (ena),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_go) w_next_state = ISSUE;
      ISSUE: w_next_state = stop ? IDLE : HOLD;
      HOLD: begin
        if (stop) begin
          w_next_state = IDLE;
        end else if (w_zero) begin
          w_next_state = (w_last && !loop) ? DONE : ISSUE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ISSUE) || (r_state == HOLD);
    w_done = (r_state == DONE);
  end

  // Datapath: operands, program store, opcode/index and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_q      <= 1'b0;
      r_load_q       <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_ctrl     <= '0;
      r_step_idx     <= '0;
      r_result_out   <= '0;
      r_result_valid <= 1'b0;
      for (int i = 0; i < NSLOT; i++) r_prog[i] <= '0;
    end else if (ena) begin
      r_start_q      <= start;
      r_load_q       <= load;
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_edge) begin
            r_alu_a <= a_in;
            r_alu_b <= b_in;
          end
          if (prog_we) r_prog[prog_addr] <= prog_op;
          if (w_go) begin
            r_step_idx <= '0;
            r_alu_ctrl <= r_prog[0];
          end
        end
        ISSUE: begin
          if (!stop) begin
            r_result_out   <= alu_result;
            r_result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (!stop && w_zero) begin
            if (!w_last) begin
              r_step_idx <= w_idx_inc;
              r_alu_ctrl <= r_prog[w_idx_inc];
            end else if (loop) begin
              r_step_idx <= '0;
              r_alu_ctrl <= r_prog[0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_ctrl     = r_alu_ctrl;
  assign step_idx     = r_step_idx;
  assign result_out   = r_result_out;
  assign result_valid = r_result_valid;
  assign busy         = w_busy;
  assign done         = w_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random traffic, every
// cycle compared against a step/age-based behavioural model.
module tb_alu_op_sequencer;

  localparam int DWELL = 4;
  localparam int CNT_W = 24;

  logic       clk = 1'b0;
  logic       rst_n, ena, load, prog_we, loop, start, stop;
  logic [2:0] a_in, b_in, prog_addr, prog_op, prog_len;
  logic [2:0] alu_a, alu_b, alu_ctrl, step_idx;
  logic [5:0] alu_result, result_out;
  logic       result_valid, busy, done;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  // Reference ALU used both as the DUT's environment and by the model.
  function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b);
    case (op)
      3'd0:    return 6'(a) + 6'(b);
      3'd1:    return 6'(a) - 6'(b);
      3'd2:    return 6'(a) * 6'(b);
      3'd3:    return {3'b000, a & b};
      3'd4:    return {3'b000, a | b};
      3'd5:    return {3'b000, a ^ b};
      3'd6:    return {a, b};
      default: return {b, a};
    endcase
  endfunction

  assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);

  alu_op_sequencer #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a_in(a_in), .b_in(b_in), .load(load),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op),
    .prog_len(prog_len), .loop(loop), .start(start), .stop(stop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .result_out(result_out), .result_valid(result_valid), .busy(busy),
    .done(done), .step_idx(step_idx)
  );

  // Model: a run is a sequence of steps, each lasting 1 + DWELL cycles;
  // m_age counts the cycle within the current step (0 = issue cycle).
  bit         m_active, m_done_cyc, m_rv, m_ps, m_pl;
  int         m_age;
  logic [2:0] m_idx, m_ctrl, m_a, m_b;
  logic [5:0] m_res;
  logic [2:0] m_prog [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_update();
    bit se, le, lst, nrv;
    if (!rst_n) begin
      m_active = 0; m_done_cyc = 0; m_rv = 0; m_ps = 0; m_pl = 0; m_age = 0;
      m_idx = '0; m_ctrl = '0; m_a = '0; m_b = '0; m_res = '0;
      for (int i = 0; i < 8; i++) m_prog[i] = '0;
    end else if (ena) begin
      se = start && !m_ps;
      le = load && !m_pl;
      m_ps = start;
      m_pl = load;
      nrv = 0;
      if (m_done_cyc) begin
        m_done_cyc = 0;
      end else if (m_active) begin
        if (stop) begin
          m_active = 0;
        end else if (m_age == 0) begin
          m_res = alu_f(m_ctrl, m_a, m_b);
          nrv = 1;
          m_age = 1;
        end else if (m_age < DWELL) begin
          m_age++;
        end else begin
          lst = (m_idx == prog_len) || (m_idx == 3'd7);
          if (!lst) begin
            m_idx = m_idx + 3'd1; m_ctrl = m_prog[m_idx]; m_age = 0;
          end else if (loop) begin
            m_idx = '0; m_ctrl = m_prog[0]; m_age = 0;
          end else begin
            m_active = 0; m_done_cyc = 1;
          end
        end
      end else begin
        if (le) begin m_a = a_in; m_b = b_in; end
        if (se && !stop) begin
          m_active = 1; m_age = 0; m_idx = '0; m_ctrl = m_prog[0];
        end
        if (prog_we) m_prog[prog_addr] = prog_op;
      end
      m_rv = nrv;
    end
  endtask

  task automatic check_outputs();
    chk("busy",         32'(busy),         32'(m_active));
    chk("done",         32'(done),         32'(m_done_cyc));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("alu_ctrl",     32'(alu_ctrl),     32'(m_ctrl));
    chk("step_idx",     32'(step_idx),     32'(m_idx));
    chk("result_out",   32'(result_out),   32'(m_res));
    chk("alu_a",        32'(alu_a),        32'(m_a));
    chk("alu_b",        32'(alu_b),        32'(m_b));
  endtask

  // Inputs are changed only between ticks, i.e. after a falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic prog_slot(input logic [2:0] addr, input logic [2:0] op);
    prog_we = 1'b1; prog_addr = addr; prog_op = op;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [2:0] b);
    a_in = a; b_in = b; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int n_done, n_rv, n_s1, first_rv;
  logic [2:0] exp_op;

  initial begin
    rst_n = 1'b0; ena = 1'b1; load = 1'b0; prog_we = 1'b0; loop = 1'b0;
    start = 1'b0; stop = 1'b0; a_in = '0; b_in = '0; prog_addr = '0;
    prog_op = '0; prog_len = '0;
    model_update();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    tick();

    // Basic three-step run.
    prog_slot(3'd0, 3'd1); prog_slot(3'd1, 3'd2); prog_slot(3'd2, 3'd3);
    prog_len = 3'd2;
    do_load(3'd5, 3'd3);
    pulse_start();
    n_done = 0; n_rv = 0; first_rv = -1;
    for (int k = 0; k < 15; k++) begin
      exp_op = 3'(k / 5 + 1);
      chk("s1_ctrl", 32'(alu_ctrl), 32'(exp_op));
      if (result_valid) begin
        if (first_rv < 0) first_rv = k;
        chk("s1_rv_phase", 32'(k % 5), 32'd1);
        chk("s1_res", 32'(result_out), 32'(alu_f(exp_op, 3'd5, 3'd3)));
        n_rv++;
      end
      if (done) n_done++;
      tick();
    end
    chk("s1_rv_count", 32'(n_rv), 32'd3);
    chk("s1_first_rv", 32'(first_rv), 32'd1);
    chk("s1_no_early_done", 32'(n_done), 32'd0);
    chk("s1_done_at_15", 32'(done), 32'd1);
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);

    // ena low during step 1 stretches it by the frozen cycles.
    pulse_start();
    n_s1 = 0; n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy && step_idx == 3'd1) n_s1++;
      if (done) n_done++;
      ena = (k >= 7 && k < 17) ? 1'b0 : 1'b1;
      tick();
      if (k >= 8 && k < 17) begin
        chk("ena_frozen_ctrl", 32'(alu_ctrl), 32'd2);
        chk("ena_frozen_idx", 32'(step_idx), 32'd1);
      end
    end
    ena = 1'b1;
    chk("ena_step1_len", 32'(n_s1), 32'd15);
    chk("ena_done_count", 32'(n_done), 32'd1);

    // start held high: one run; mid-run start/load/prog_we ignored.
    start = 1'b1;
    tick();
    n_done = 0; n_rv = 0;
    for (int k = 1; k < 30; k++) begin
      start   = (k == 4) ? 1'b0 : 1'b1;
      load    = (k == 6);
      a_in    = (k == 6) ? 3'd7 : 3'd5;
      prog_we = (k == 8);
      prog_addr = 3'd0; prog_op = 3'd7;
      if (result_valid) n_rv++;
      if (done) n_done++;
      tick();
    end
    start = 1'b0; load = 1'b0; prog_we = 1'b0;
    tick();
    chk("held_done_count", 32'(n_done), 32'd1);
    chk("held_rv_count", 32'(n_rv), 32'd3);
    chk("held_alu_a", 32'(alu_a), 32'd5);
    pulse_start();
    chk("held_slot0", 32'(alu_ctrl), 32'd1);
    repeat (16) tick();

    // stop on the final HOLD cycle suppresses done; next run is normal.
    pulse_start();
    repeat (14) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("fstop_busy", 32'(busy), 32'd0);
    n_done = 0;
    repeat (4) begin
      if (done) n_done++;
      tick();
    end
    chk("fstop_no_done", 32'(n_done), 32'd0);
    pulse_start();
    n_done = 0;
    repeat (20) begin
      if (done) n_done++;
      tick();
    end
    chk("fstop_rerun_done", 32'(n_done), 32'd1);

    // Looping two-slot program, then abort.
    prog_slot(3'd0, 3'd4); prog_slot(3'd1, 3'd6);
    prog_len = 3'd1; loop = 1'b1;
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      chk("loop_ctrl", 32'(alu_ctrl), ((c / 5) % 2 == 1) ? 32'd6 : 32'd4);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop_busy", 32'(busy), 32'd0);
    n_done = 0;
    repeat (5) begin
      if (done) n_done++;
      tick();
    end
    chk("loop_stop_no_done", 32'(n_done), 32'd0);

    // Reset in the middle of a run clears everything including the program.
    pulse_start();
    repeat (7) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_result", 32'(result_out), 32'd0);
    prog_len = 3'd0; loop = 1'b0;
    do_load(3'd2, 3'd3);
    pulse_start();
    chk("rst_issue_op0", 32'(alu_ctrl), 32'd0);
    tick();
    chk("rst_res_op0", 32'(result_out), 32'(alu_f(3'd0, 3'd2, 3'd3)));
    repeat (6) tick();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      ena       = ($urandom_range(0, 9) != 0);
      stop      = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 3) == 0);
      load      = ($urandom_range(0, 3) == 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = 3'($urandom);
      prog_op   = 3'($urandom);
      a_in      = 3'($urandom);
      b_in      = 3'($urandom);
      if ($urandom_range(0, 19) == 0) prog_len = 3'($urandom);
      if ($urandom_range(0, 19) == 0) loop = ~loop;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
